// File: rtl/nrisc_pkg.sv
// Shared opcode constants, scheduler state encoding and opcode helper for the
// nrisc ALU scheduling slice.
package nrisc_pkg;

  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NOP = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_BNZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } sched_state_t;

  function automatic logic op_supported(input logic [2:0] op);
    case (op)
      OP_SUM, OP_SUB, OP_MUL, OP_BEQ, OP_BNZ: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester and shared-ALU signal bundle for alu_scheduler.
// slave = scheduler side, master = requesters plus ALU side.
interface alu_scheduler_if;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] beq0, beq1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic [7:0] result, jump;
  logic [2:0] alu_operation;
  logic [7:0] alu_data_0, alu_data_1, alu_r_beq;
  logic [7:0] alu_solution, alu_jump_data;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, beq0, beq1,
    input  alu_solution, alu_jump_data,
    output gnt0, gnt1, done0, done1, result, jump,
    output alu_operation, alu_data_0, alu_data_1, alu_r_beq
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, beq0, beq1,
    output alu_solution, alu_jump_data,
    input  gnt0, gnt1, done0, done1, result, jump,
    input  alu_operation, alu_data_0, alu_data_1, alu_r_beq
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-way winner select. Round-robin on ties by default; with
// ALU_SCHED_FIXED_PRIO_EN defined requester 0 always wins and no pointer exists.
module alu_rr_arbiter (
`ifndef ALU_SCHED_FIXED_PRIO_EN
  input  logic       clock,
  input  logic       reset,
`endif
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  logic last_q;  // id of the requester granted most recently

  always_comb begin
    gnt = '0;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       last_q <= 1'b1;
    else if (gnt[0]) last_q <= 1'b0;
    else if (gnt[1]) last_q <= 1'b1;
  end
`endif

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU between two requesters: IDLE -> ISSUE -> CAPTURE.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0) arbitration.
module alu_scheduler
  import nrisc_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  alu_scheduler_if.slave bus
);

  sched_state_t state_q, state_d;
  logic [1:0]   arb_gnt;
  logic         arb_en;
  logic [2:0]   op_q;
  logic [7:0]   a_q, b_q, beq_q;
  logic         owner_q;

  // Grants only from IDLE and never in a reset cycle.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  alu_rr_arbiter u_arb (
`ifndef ALU_SCHED_FIXED_PRIO_EN
    .clock  (clock),
    .reset  (reset),
`endif
    .enable (arb_en),
    .req    ({bus.req1, bus.req0}),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|arb_gnt) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt0          = arb_gnt[0];
    bus.gnt1          = arb_gnt[1];
    bus.alu_operation = OP_NOP;
    bus.alu_data_0    = '0;
    bus.alu_data_1    = '0;
    bus.alu_r_beq     = '0;
    if (state_q == ST_ISSUE) begin
      bus.alu_operation = op_q;
      bus.alu_data_0    = a_q;
      bus.alu_data_1    = b_q;
      bus.alu_r_beq     = beq_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      beq_q      <= '0;
      owner_q    <= 1'b0;
      bus.result <= '0;
      bus.jump   <= '0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      if (|arb_gnt) begin
        owner_q <= arb_gnt[1];
        op_q    <= arb_gnt[1] ? bus.op1  : bus.op0;
        a_q     <= arb_gnt[1] ? bus.a1   : bus.a0;
        b_q     <= arb_gnt[1] ? bus.b1   : bus.b0;
        beq_q   <= arb_gnt[1] ? bus.beq1 : bus.beq0;
      end
      if (state_q == ST_CAPTURE) begin
        bus.result <= op_supported(op_q) ? bus.alu_solution : 8'h00;
        bus.jump   <= (op_q == OP_BNZ) ? bus.alu_jump_data : 8'h00;
        bus.done0  <= !owner_q;
        bus.done1  <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a registered ALU model on the shared port.
// Honours ALU_SCHED_FIXED_PRIO_EN for the expected grant order.
module tb_alu_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_scheduler_if bus ();

  alu_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Registered ALU: samples operands at the rising edge ending ISSUE.
  always @(posedge clock) begin
    case (bus.alu_operation)
      3'b000: begin bus.alu_solution <= bus.alu_data_0 + bus.alu_data_1; bus.alu_jump_data <= 8'h00; end
      3'b001: begin bus.alu_solution <= bus.alu_data_0 - bus.alu_data_1; bus.alu_jump_data <= 8'h00; end
      3'b010: begin bus.alu_solution <= 8'(bus.alu_data_0 * bus.alu_data_1); bus.alu_jump_data <= 8'h00; end
      3'b110: begin
        bus.alu_solution  <= (bus.alu_data_0 == bus.alu_data_1) ? 8'h01 : 8'h00;
        bus.alu_jump_data <= (bus.alu_data_0 == bus.alu_data_1) ? bus.alu_data_1 : 8'h00;
      end
      3'b111: begin
        bus.alu_solution  <= bus.alu_data_0;
        bus.alu_jump_data <= (bus.alu_r_beq != 8'h00) ? bus.alu_data_1 : bus.alu_data_0;
      end
      default: begin bus.alu_solution <= 8'h00; bus.alu_jump_data <= 8'h00; end
    endcase
  end

  typedef struct {
    bit       sel;
    bit [2:0] op;
    bit [7:0] a, b, beq;
    bit [7:0] exp_result, exp_jump;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester drops req after its grant but keeps operands stable.
  task automatic do_op(input vec_t v);
    @(negedge clock);
    if (v.sel) begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b; bus.beq1 = v.beq;
    end else begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b; bus.beq0 = v.beq;
    end
    #1;
    check("gnt_own",   v.sel ? bus.gnt1 : bus.gnt0, 1);
    check("gnt_other", v.sel ? bus.gnt0 : bus.gnt1, 0);
    check("done_idle", {bus.done1, bus.done0}, 0);
    @(negedge clock);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
    check("issue_op", bus.alu_operation, v.op);
    check("issue_a",  bus.alu_data_0, v.a);
    check("issue_b",  bus.alu_data_1, v.b);
    @(negedge clock); #1;
    check("capture_op",   bus.alu_operation, 3'b011);
    check("capture_done", {bus.done1, bus.done0}, 0);
    @(negedge clock); #1;
    check("done_own", v.sel ? {bus.done1, bus.done0} : {bus.done0, bus.done1}, 2'b10);
    check("result",   bus.result, v.exp_result);
    check("jump",     bus.jump, v.exp_jump);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   gid[4];
  int   gcyc[4];
  int   ng;
  bit   saw_done;

  initial begin
    vecs[0] = '{0, 3'b000, 8'h05, 8'h03, 8'h00, 8'h08, 8'h00};
    vecs[1] = '{1, 3'b010, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{1, 3'b111, 8'h12, 8'h34, 8'h00, 8'h12, 8'h12};
    vecs[3] = '{1, 3'b111, 8'h12, 8'h34, 8'h01, 8'h12, 8'h34};
    vecs[4] = '{0, 3'b001, 8'h03, 8'h05, 8'h00, 8'hFE, 8'h00};
    vecs[5] = '{0, 3'b101, 8'h07, 8'h09, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1, 3'b110, 8'h05, 8'h05, 8'h00, 8'h01, 8'h00};
    vecs[7] = '{0, 3'b000, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00};

    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0; bus.beq0 = 0; bus.beq1 = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_gnt",    {bus.gnt1, bus.gnt0}, 0);
    check("rst_done",   {bus.done1, bus.done0}, 0);
    check("rst_result", bus.result, 0);
    check("rst_jump",   bus.jump, 0);
    check("rst_aluop",  bus.alu_operation, 3'b011);
    check("rst_alud",   {bus.alu_data_0, bus.alu_data_1, bus.alu_r_beq}, 0);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Continuous contention from a fresh reset.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    bus.req0 = 1; bus.op0 = 3'b000; bus.a0 = 8'h01; bus.b0 = 8'h01;
    bus.req1 = 1; bus.op1 = 3'b000; bus.a1 = 8'h01; bus.b1 = 8'h01;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        check("rr_onehot", bus.gnt0 & bus.gnt1, 0);
        gid[ng] = bus.gnt1 ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
    end
    @(negedge clock);
    bus.req0 = 0; bus.req1 = 0;
    check("rr_count", ng, 4);
    for (int i = 0; i < 4 && i < ng; i++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      check("rr_order", gid[i], 0);
`else
      check("rr_order", gid[i], i % 2);
`endif
      if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    repeat (2) @(negedge clock);
    #1;
    check("rr_result", bus.result, 8'h02);

    // Reset during ISSUE of a SUB aborts it.
    @(negedge clock);
    bus.req0 = 1; bus.op0 = 3'b001; bus.a0 = 8'h09; bus.b0 = 8'h04; bus.beq0 = 0;
    #1;
    check("abort_gnt", bus.gnt0, 1);
    @(negedge clock);
    bus.req0 = 0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_idle_op", bus.alu_operation, 3'b011);
    check("abort_result",  bus.result, 0);
    check("abort_jump",    bus.jump, 0);
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
      if (bus.done0 || bus.done1) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_result_hold", bus.result, 0);
    v = '{0, 3'b001, 8'h09, 8'h04, 8'h00, 8'h05, 8'h00};
    do_op(v);

    // No grant in a reset cycle even with a request pending.
    @(negedge clock);
    reset = 1'b1; bus.req1 = 1; bus.op1 = 3'b000; bus.a1 = 8'h02; bus.b1 = 8'h02; bus.beq1 = 0;
    #1;
    check("rst_cycle_gnt", {bus.gnt1, bus.gnt0}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    v = '{1, 3'b000, 8'h02, 8'h02, 8'h00, 8'h04, 8'h00};
    do_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
